// File: rtl/kgp_branch_pkg.sv
// rtl/kgp_branch_pkg.sv - branch opcodes and PC-unit FSM encoding for the KGP-RISC core
package kgp_branch_pkg;

   localparam int BR_OP_W = 4;

   localparam logic [BR_OP_W-1:0] BR_NONE   = 4'd0;
   localparam logic [BR_OP_W-1:0] BR_UNCOND = 4'd1;
   localparam logic [BR_OP_W-1:0] BR_LTZ    = 4'd2;
   localparam logic [BR_OP_W-1:0] BR_Z      = 4'd3;
   localparam logic [BR_OP_W-1:0] BR_NZ     = 4'd4;
   localparam logic [BR_OP_W-1:0] BR_LINK   = 4'd5;
   localparam logic [BR_OP_W-1:0] BR_CY     = 4'd6;
   localparam logic [BR_OP_W-1:0] BR_NCY    = 4'd7;
   localparam logic [BR_OP_W-1:0] BR_REG    = 4'd8;
   localparam logic [BR_OP_W-1:0] BR_HALT   = 4'd9;

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_HALT = 1'b1
   } pc_state_t;

endpackage

// File: rtl/pc_branch_unit_flag_reg.sv
// rtl/pc_branch_unit_flag_reg.sv - carry/zero/sign flag register with write enable
module flag_reg (
   input  logic       clk,
   input  logic       rst,
   input  logic       we,
   input  logic [2:0] d,
   output logic [2:0] q
);

   always_ff @(posedge clk) begin
      if (rst)
         q <= '0;
      else if (we)
         q <= d;
   end

endmodule

// File: rtl/pc_branch_unit.sv
// rtl/pc_branch_unit.sv - program counter, flags, branch resolution and halt for KGP-RISC
module pc_branch_unit
   import kgp_branch_pkg::*;
#(
   parameter int              PC_W     = 32,
   parameter int              OFS_W    = 26,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic [BR_OP_W-1:0] br_op,
   input  logic [OFS_W-1:0]   offset,
   input  logic [PC_W-1:0]    rs_val,
   input  logic               flag_we,
   input  logic               carry_in,
   input  logic               zero_in,
   input  logic               sign_in,
   output logic [PC_W-1:0]    pc,
   output logic               taken,
   output logic               flush,
   output logic               link_we,
   output logic [PC_W-1:0]    link_addr,
   output logic               carry,
   output logic               zero,
   output logic               sign,
   output logic               halted
);

   pc_state_t       state, state_nxt;
   logic            cond;
   logic            run_en;
   logic [2:0]      flags;
   logic [PC_W-1:0] seq, tgt, ofs_sext;

   flag_reg u_flag_reg (
      .clk (clk),
      .rst (rst),
      .we  (flag_we),
      .d   ({carry_in, zero_in, sign_in}),
      .q   (flags)
   );

   assign carry = flags[2];
   assign zero  = flags[1];
   assign sign  = flags[0];

   assign seq       = pc + PC_W'(4);
   assign ofs_sext  = {{(PC_W-OFS_W){offset[OFS_W-1]}}, offset};
   assign tgt       = (br_op == BR_REG) ? (rs_val & ~PC_W'(3)) : (seq + (ofs_sext << 2));
   assign link_addr = seq;

   // Conditions look only at the registered flags, so a same-cycle flag write is not seen.
   always_comb begin
      cond = 1'b0;
      case (br_op)
         BR_UNCOND, BR_LINK, BR_REG: cond = 1'b1;
         BR_LTZ:                     cond = rs_val[PC_W-1];
         BR_Z:                       cond = (rs_val == '0);
         BR_NZ:                      cond = (rs_val != '0);
         BR_CY:                      cond = carry;
         BR_NCY:                     cond = ~carry;
         BR_NONE, BR_HALT:           cond = 1'b0;
         default:                    cond = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst)
         state <= ST_RUN;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (state == ST_RUN && en && br_op == BR_HALT)
         state_nxt = ST_HALT;
   end

   always_comb begin
      run_en  = (state == ST_RUN) && en;
      taken   = run_en && cond;
      link_we = run_en && (br_op == BR_LINK);
      halted  = (state == ST_HALT);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc    <= RESET_PC;
         flush <= 1'b0;
      end else begin
         flush <= taken;
         if (run_en && br_op != BR_HALT)
            pc <= taken ? tgt : seq;
      end
   end

endmodule

// File: tb/tb_pc_branch_unit.sv
// tb/tb_pc_branch_unit.sv - directed and randomized self-checking bench for pc_branch_unit
module tb_pc_branch_unit;
   import kgp_branch_pkg::*;

   localparam int PC_W  = 32;
   localparam int OFS_W = 26;

   logic              clk = 1'b0;
   logic              rst, en, flag_we, carry_in, zero_in, sign_in;
   logic [3:0]        br_op;
   logic [OFS_W-1:0]  offset;
   logic [PC_W-1:0]   rs_val;
   logic [PC_W-1:0]   pc, link_addr;
   logic              taken, flush, link_we, carry, zero, sign, halted;

   int checks   = 0;
   int failures = 0;

   logic [31:0] m_pc;
   bit          m_carry, m_zero, m_sign, m_flush, m_halted;

   pc_branch_unit #(.PC_W(PC_W), .OFS_W(OFS_W), .RESET_PC('0)) dut (
      .clk(clk), .rst(rst), .en(en), .br_op(br_op), .offset(offset), .rs_val(rs_val),
      .flag_we(flag_we), .carry_in(carry_in), .zero_in(zero_in), .sign_in(sign_in),
      .pc(pc), .taken(taken), .flush(flush), .link_we(link_we), .link_addr(link_addr),
      .carry(carry), .zero(zero), .sign(sign), .halted(halted)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic bit ref_cond(input logic [3:0] op, input logic [31:0] rv, input bit cy);
      case (op)
         4'd1, 4'd5, 4'd8: return 1'b1;
         4'd2:             return rv[31];
         4'd3:             return rv == 32'd0;
         4'd4:             return rv != 32'd0;
         4'd6:             return cy;
         4'd7:             return !cy;
         default:          return 1'b0;
      endcase
   endfunction

   // One clock: check combinational outputs mid-cycle, advance the model, check registers after the edge.
   task automatic cycle();
      bit                 t;
      logic signed [31:0] so;
      logic [31:0]        tgt;
      @(negedge clk);
      t = !m_halted && en && ref_cond(br_op, rs_val, m_carry);
      chk("taken", taken, t);
      chk("link_we", link_we, !m_halted && en && br_op == 4'd5);
      chk("link_addr", link_addr, m_pc + 32'd4);
      so = $signed(offset);
      if (br_op == 4'd8) tgt = rs_val & ~32'd3;
      else               tgt = m_pc + 32'd4 + so * 4;
      if (rst) begin
         m_pc = 32'd0; m_carry = 0; m_zero = 0; m_sign = 0; m_flush = 0; m_halted = 0;
      end else begin
         if (!m_halted && en) begin
            if (br_op == 4'd9) begin
               m_halted = 1; m_flush = 0;
            end else begin
               m_pc = t ? tgt : m_pc + 32'd4;
               m_flush = t;
            end
         end else begin
            m_flush = 0;
         end
         if (flag_we) begin
            m_carry = carry_in; m_zero = zero_in; m_sign = sign_in;
         end
      end
      @(posedge clk);
      #1;
      chk("pc", pc, m_pc);
      chk("flush", flush, m_flush);
      chk("halted", halted, m_halted);
      chk("flags", {carry, zero, sign}, {m_carry, m_zero, m_sign});
   endtask

   task automatic step(input bit e, input logic [3:0] op, input int ofs, input logic [31:0] rv);
      rst = 0; flag_we = 0; en = e; br_op = op; offset = ofs[OFS_W-1:0]; rs_val = rv;
      cycle();
   endtask

   initial begin
      int ofs;
      logic [3:0] op;
      logic [31:0] rv;

      rst = 1; en = 0; br_op = 4'd0; offset = '0; rs_val = '0;
      flag_we = 0; carry_in = 0; zero_in = 0; sign_in = 0;
      repeat (2) @(posedge clk);
      #1;
      m_pc = 32'd0; m_carry = 0; m_zero = 0; m_sign = 0; m_flush = 0; m_halted = 0;
      chk("reset_pc", pc, 32'd0);
      chk("reset_flush", flush, 1'b0);
      chk("reset_halted", halted, 1'b0);
      chk("reset_flags", {carry, zero, sign}, 3'b000);

      // Sequential fetch
      for (int i = 1; i <= 4; i++) begin
         step(1, BR_NONE, 0, 32'd0);
         chk("seq_pc", pc, 32'(4 * i));
         chk("seq_flush", flush, 1'b0);
      end

      // Conditional branch taken / not taken
      step(1, BR_REG, 0, 32'h100);
      chk("setpc_100", pc, 32'h100);
      step(1, BR_Z, -2, 32'd0);
      chk("bz_taken_pc", pc, 32'hFC);
      chk("bz_taken_flush", flush, 1'b1);
      step(1, BR_NONE, 0, 32'd0);
      chk("bz_flush_drop", flush, 1'b0);
      step(1, BR_REG, 0, 32'h100);
      step(1, BR_Z, -2, 32'd5);
      chk("bz_not_taken_pc", pc, 32'h104);
      chk("bz_not_taken_flush", flush, 1'b0);

      // Link and register jump
      step(1, BR_REG, 0, 32'h40);
      rst = 0; flag_we = 0; en = 1; br_op = BR_LINK; offset = 26'd3; rs_val = 32'd0;
      #2;
      chk("bl_link_we", link_we, 1'b1);
      chk("bl_link_addr", link_addr, 32'h44);
      cycle();
      chk("bl_pc", pc, 32'h50);
      step(1, BR_REG, 0, 32'h203);
      chk("jr_pc", pc, 32'h200);

      // Flag ordering: same-cycle flag write is invisible to the branch
      rst = 0; en = 1; br_op = BR_CY; offset = 26'd8; rs_val = 32'd0;
      flag_we = 1; carry_in = 1; zero_in = 0; sign_in = 1;
      #2;
      chk("cy_same_cycle", taken, 1'b0);
      cycle();
      chk("cy_new_carry", carry, 1'b1);
      chk("cy_not_taken_pc", pc, 32'h204);
      step(1, BR_CY, 8, 32'd0);
      chk("cy_taken_pc", pc, 32'h228);
      rst = 0; en = 1; br_op = BR_NCY; offset = 26'd8; rs_val = 32'd0;
      flag_we = 1; carry_in = 0; zero_in = 1; sign_in = 0;
      #2;
      chk("ncy_same_cycle", taken, 1'b0);
      cycle();
      step(1, BR_NCY, 8, 32'd0);
      chk("ncy_taken_pc", pc, 32'h250);

      // Wrap-around, halt, reset out of halt
      step(1, BR_REG, 0, 32'hFFFF_FFFC);
      step(1, BR_NONE, 0, 32'd0);
      chk("wrap_pc", pc, 32'd0);
      step(1, BR_NONE, 0, 32'd0);
      step(1, BR_HALT, 0, 32'd0);
      chk("halt_rise", halted, 1'b1);
      chk("halt_pc", pc, 32'd4);
      for (int i = 0; i < 5; i++) begin
         step(1, BR_UNCOND, 16, 32'd0);
         chk("halt_hold_pc", pc, 32'd4);
         chk("halt_hold_flag", halted, 1'b1);
         chk("halt_no_flush", flush, 1'b0);
      end
      rst = 1; flag_we = 0;
      cycle();
      chk("halt_reset_pc", pc, 32'd0);
      chk("halt_reset_halted", halted, 1'b0);

      // Reset in the same cycle as a taken branch
      step(1, BR_NONE, 0, 32'd0);
      rst = 1; en = 1; br_op = BR_UNCOND; offset = 26'd100; flag_we = 0;
      cycle();
      chk("midbr_reset_pc", pc, 32'd0);
      chk("midbr_reset_flush", flush, 1'b0);

      // Randomized traffic against the reference model
      for (int i = 0; i < 400; i++) begin
         op = 4'($urandom_range(0, 15));
         if (op == BR_HALT && $urandom_range(0, 3) != 0) op = BR_NONE;
         case ($urandom_range(0, 3))
            0:       rv = 32'd0;
            1:       rv = $urandom | 32'h8000_0000;
            default: rv = $urandom;
         endcase
         if ($urandom_range(0, 3) == 0) ofs = int'($urandom);
         else                           ofs = int'($urandom_range(0, 2000)) - 1000;
         en       = ($urandom_range(0, 4) != 0);
         br_op    = op;
         offset   = ofs[OFS_W-1:0];
         rs_val   = rv;
         flag_we  = $urandom_range(0, 1) == 1;
         carry_in = $urandom_range(0, 1) == 1;
         zero_in  = $urandom_range(0, 1) == 1;
         sign_in  = $urandom_range(0, 1) == 1;
         rst      = m_halted ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 49) == 0);
         cycle();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pc_branch_unit.md
# pc_branch_unit

- Holds the program counter and the carry/zero/sign flag register for the KGP-RISC core.
- Sits directly upstream of the per-bit DFF state elements and the instruction-fetch path; its registered PC is what fetch consumes every cycle.
- Evaluates the branch condition for the current instruction, computes the next PC and produces the link write for `bl`.
- Implements the halt state: the PC freezes until reset.

## Interface
Parameters:
- `PC_W`, 32, PC / data width.
- `OFS_W`, 26, branch offset field width (signed, in words).
- `RESET_PC`, 0, PC value after reset.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `en` in 1: the current instruction is valid and the PC may advance this cycle.
- `br_op` in 4: branch opcode, from the shared package.
- `offset` in OFS_W: signed word offset from the decoder.
- `rs_val` in PC_W: source register value, used for the `ltz`/`z`/`nz` tests and as the jump target for `BR_REG`.
- `flag_we` in 1: ALU flag write enable.
- `carry_in`, `zero_in`, `sign_in` in 1 each: ALU flags.
- `pc` out PC_W: registered program counter.
- `taken` out 1: combinational; branch taken this cycle.
- `flush` out 1: registered; one-cycle pulse after a taken branch.
- `link_we` out 1: combinational; write `link_addr` to r31.
- `link_addr` out PC_W: `pc + 4`.
- `carry`, `zero`, `sign` out 1 each: registered flags.
- `halted` out 1: registered; high in the HALT state.

## Operation
Branch opcodes:
- `BR_NONE`=0
- `BR_UNCOND`=1
- `BR_LTZ`=2: rs_val[PC_W-1]
- `BR_Z`=3: rs_val==0
- `BR_NZ`=4: rs_val!=0
- `BR_LINK`=5: unconditional, plus link
- `BR_CY`=6: carry==1
- `BR_NCY`=7: carry==0
- `BR_REG`=8: jump to rs_val
- `BR_HALT`=9
- Codes 10–15 are treated as `BR_NONE`.

Next-PC rules:
- `seq = pc + 4`.
- `tgt = seq + (sext(offset) << 2)`, except `BR_REG`, where `tgt = rs_val & ~3`.
- All adds are modulo 2^PC_W; wrap-around is silent, with no trap.

FSM states:
- **RUN**, when `en`:
  - `pc <= taken ? tgt : seq`.
  - `flush <= taken`.
  - `BR_HALT` → go to HALT; `pc` holds its value (does not advance).
- **RUN**, when `!en`: `pc` holds; `flush <= 0`.
- **HALT**:
  - `pc` holds; `halted=1`.
  - `taken`, `link_we` and `flush` stay 0.
  - `en` and `br_op` are ignored.
  - Only `rst` leaves HALT.

Outputs:
- `taken` = state==RUN && en && condition(br_op).
- `link_we` = state==RUN && en && br_op==`BR_LINK`.
- `link_addr` = `seq`, always driven.

Flags:
- Updated on `flag_we`, in any state.
- Conditions use the registered (old) flag values.
- A `flag_we` in the same cycle as `BR_CY` does not affect that branch; the new value is visible from the next cycle.

Reset (synchronous, wins over everything):
- `pc=RESET_PC`
- `carry=zero=sign=0`
- `flush=0`, `halted=0`
- state RUN
- Reset mid-branch discards the target.

## Timing
- Next-PC latency is 1 cycle: the edge after a valid cycle shows the new `pc`.
- `taken` and `link_we` are valid in the same cycle as `en`; the register file samples them on that edge.
- `flush` is high for exactly the one cycle in which `pc` first shows the branch target.
- Back-to-back taken branches give consecutive `flush` cycles.
- HALT takes effect on the edge that samples `BR_HALT`; `halted` rises on that edge.
- No combinational path from `carry_in`/`zero_in`/`sign_in` to any output.

## Structure
- Package `kgp_branch_pkg` holds:
  - the `br_op` localparams;
  - `BR_OP_W=4`;
  - the state encoding: RUN=0, HALT=1.
- Sub-module `flag_reg`: 3-bit register with synchronous reset and write enable. Instantiated once.
- Condition mux and adders stay inline in `pc_branch_unit`.

## Test plan
- **Reset + sequential:** assert rst with RESET_PC=0; release it; hold en=1 with `BR_NONE` for 4 cycles → pc reads 0, 4, 8, 12, 16; flush stays 0.
- **Conditional:** pc=0x100, `BR_Z`, offset=−2:
  - rs_val=0 → taken=1; next pc=0xFC; flush=1 for one cycle.
  - rs_val=5 → not taken; next pc=0x104.
- **Link + register jump:**
  - pc=0x40, `BR_LINK`, offset=3 → link_we=1, link_addr=0x44; next pc=0x50.
  - `BR_REG`, rs_val=0x203 → next pc=0x200.
- **Flag ordering:** carry=0; in one cycle drive flag_we=1, carry_in=1 and `BR_CY` → not taken; the next `BR_CY` is taken. `BR_NCY` is the mirror case.
- **Wrap + halt + reset:**
  - pc=0xFFFFFFFC with `BR_NONE` → pc=0.
  - `BR_HALT` → pc frozen and halted=1 for 5 cycles, even with `BR_UNCOND` driven.
  - rst → pc=0, halted=0.
- **Mid-branch reset:** rst in the same cycle as a taken `BR_UNCOND` → pc=RESET_PC and flush=0 on the next cycle.
